// File: rtl/core_id_pipe.sv
// ============================================================================
// Module   : core_id_pipe
// Purpose  : Handshaked RV32I decode stage with 2-entry skid buffer,
//            load-use stall, flush and a registered output stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_id_pipe #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int ALU_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_addr,
  output logic [RA_W-1:0]  reg1_raddr,
  output logic [RA_W-1:0]  reg2_raddr,
  input  logic [XLEN-1:0]  reg1_rdata,
  input  logic [XLEN-1:0]  reg2_rdata,
  input  logic             haz_load,
  input  logic [RA_W-1:0]  haz_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic [XLEN-1:0]  out_addr,
  output logic             out_we,
  output logic [RA_W-1:0]  out_rd,
  output logic [XLEN-1:0]  out_opnum1,
  output logic [XLEN-1:0]  out_opnum2,
  output logic [ALU_W-1:0] out_alu_func,
  output logic [XLEN-1:0]  out_imm,
  output logic [XLEN-1:0]  out_store_data,
  output logic             out_is_load,
  output logic             out_is_store,
  output logic             out_is_branch,
  output logic             out_is_jump,
  output logic             out_illegal
);

  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_imm    = 7'b0010011;
  localparam logic [6:0] c_op_reg    = 7'b0110011;

  localparam logic [ALU_W-1:0] c_alu_add  = ALU_W'(0);
  localparam logic [ALU_W-1:0] c_alu_sub  = ALU_W'(1);
  localparam logic [ALU_W-1:0] c_alu_xor  = ALU_W'(2);
  localparam logic [ALU_W-1:0] c_alu_or   = ALU_W'(3);
  localparam logic [ALU_W-1:0] c_alu_and  = ALU_W'(4);
  localparam logic [ALU_W-1:0] c_alu_sll  = ALU_W'(5);
  localparam logic [ALU_W-1:0] c_alu_srl  = ALU_W'(6);
  localparam logic [ALU_W-1:0] c_alu_sra  = ALU_W'(7);
  localparam logic [ALU_W-1:0] c_alu_slt  = ALU_W'(8);
  localparam logic [ALU_W-1:0] c_alu_sltu = ALU_W'(9);

  localparam logic [XLEN-1:0] c_four = XLEN'(4);

  // Skid buffer: entry 0 is always the head, entry 1 the tail when full.
  logic [31:0]     r_inst0, r_inst1;
  logic [XLEN-1:0] r_addr0, r_addr1;
  logic [1:0]      r_count;
  logic            r_in_ready;

  logic             r_out_valid;
  logic [31:0]      r_out_inst;
  logic [XLEN-1:0]  r_out_addr;
  logic             r_out_we;
  logic [RA_W-1:0]  r_out_rd;
  logic [XLEN-1:0]  r_out_op1;
  logic [XLEN-1:0]  r_out_op2;
  logic [ALU_W-1:0] r_out_func;
  logic [XLEN-1:0]  r_out_imm;
  logic [XLEN-1:0]  r_out_sdata;
  logic             r_out_load, r_out_store, r_out_branch, r_out_jump, r_out_illegal;

  logic [6:0]      w_opcode;
  logic [2:0]      w_f3;
  logic [RA_W-1:0] w_rs1, w_rs2, w_rd;
  logic            w_f7_ok;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_shamt;
  logic [ALU_W-1:0] w_func_f3;

  logic [XLEN-1:0]  w_op1, w_op2, w_imm;
  logic [ALU_W-1:0] w_func;
  logic             w_we, w_is_load, w_is_store, w_is_branch, w_is_jump, w_illegal;
  logic             w_use_rs1, w_use_rs2;

  logic       w_head_valid, w_hazard, w_issue, w_push;
  logic [1:0] w_count_next;

  assign w_opcode = r_inst0[6:0];
  assign w_f3     = r_inst0[14:12];
  assign w_rd     = r_inst0[11:7];
  assign w_rs1    = r_inst0[19:15];
  assign w_rs2    = r_inst0[24:20];
  assign w_f7_ok  = (r_inst0[31:25] == 7'h00) || (r_inst0[31:25] == 7'h20);

  assign w_imm_i = {{(XLEN-12){r_inst0[31]}}, r_inst0[31:20]};
  assign w_imm_s = {{(XLEN-12){r_inst0[31]}}, r_inst0[31:25], r_inst0[11:7]};
  assign w_imm_b = {{(XLEN-12){r_inst0[31]}}, r_inst0[7], r_inst0[30:25], r_inst0[11:8], 1'b0};
  assign w_imm_u = {{(XLEN-32){r_inst0[31]}}, r_inst0[31:12], 12'b0};
  assign w_imm_j = {{(XLEN-20){r_inst0[31]}}, r_inst0[19:12], r_inst0[20], r_inst0[30:21], 1'b0};
  assign w_shamt = {{(XLEN-5){1'b0}}, r_inst0[24:20]};

  assign reg1_raddr = w_rs1;
  assign reg2_raddr = w_rs2;

  // Bit 30 picks SUB/SRA for register ops and SRAI for immediate shifts.
  always_comb begin
    w_func_f3 = c_alu_add;
    case (w_f3)
      3'b000:  w_func_f3 = r_inst0[30] ? c_alu_sub : c_alu_add;
      3'b001:  w_func_f3 = c_alu_sll;
      3'b010:  w_func_f3 = c_alu_slt;
      3'b011:  w_func_f3 = c_alu_sltu;
      3'b100:  w_func_f3 = c_alu_xor;
      3'b101:  w_func_f3 = r_inst0[30] ? c_alu_sra : c_alu_srl;
      3'b110:  w_func_f3 = c_alu_or;
      default: w_func_f3 = c_alu_and;
    endcase
  end

  always_comb begin
    w_op1       = '0;
    w_op2       = '0;
    w_func      = c_alu_add;
    w_imm       = '0;
    w_we        = 1'b0;
    w_is_load   = 1'b0;
    w_is_store  = 1'b0;
    w_is_branch = 1'b0;
    w_is_jump   = 1'b0;
    w_illegal   = 1'b0;
    w_use_rs1   = 1'b0;
    w_use_rs2   = 1'b0;
    case (w_opcode)
      c_op_reg: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_op1     = reg1_rdata;
        w_op2     = reg2_rdata;
        w_func    = w_func_f3;
        w_we      = 1'b1;
        w_illegal = !w_f7_ok;
      end
      c_op_imm: begin
        w_use_rs1 = 1'b1;
        w_op1     = reg1_rdata;
        w_imm     = w_imm_i;
        w_we      = 1'b1;
        if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
          w_op2     = w_shamt;
          w_func    = w_func_f3;
          w_illegal = !w_f7_ok;
        end else begin
          w_op2  = w_imm_i;
          w_func = (w_f3 == 3'b000) ? c_alu_add : w_func_f3;
        end
      end
      c_op_lui: begin
        w_op2 = w_imm_u;
        w_imm = w_imm_u;
        w_we  = 1'b1;
      end
      c_op_auipc: begin
        w_op1 = in_addr_head();
        w_op2 = w_imm_u;
        w_imm = w_imm_u;
        w_we  = 1'b1;
      end
      c_op_jal: begin
        w_op1     = r_addr0;
        w_op2     = c_four;
        w_imm     = w_imm_j;
        w_is_jump = 1'b1;
        w_we      = 1'b1;
      end
      c_op_jalr: begin
        w_use_rs1 = 1'b1;
        w_op1     = r_addr0;
        w_op2     = c_four;
        w_imm     = w_imm_i;
        w_is_jump = 1'b1;
        w_we      = 1'b1;
      end
      c_op_load: begin
        w_use_rs1 = 1'b1;
        w_op1     = reg1_rdata;
        w_op2     = w_imm_i;
        w_imm     = w_imm_i;
        w_is_load = 1'b1;
        w_we      = 1'b1;
        w_illegal = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
      end
      c_op_store: begin
        w_use_rs1  = 1'b1;
        w_use_rs2  = 1'b1;
        w_op1      = reg1_rdata;
        w_op2      = w_imm_s;
        w_imm      = w_imm_s;
        w_is_store = 1'b1;
        w_illegal  = (w_f3[2] == 1'b1) || (w_f3 == 3'b011);
      end
      c_op_branch: begin
        w_use_rs1   = 1'b1;
        w_use_rs2   = 1'b1;
        w_op1       = reg1_rdata;
        w_op2       = reg2_rdata;
        w_imm       = w_imm_b;
        w_is_branch = 1'b1;
        case (w_f3)
          3'b000, 3'b001: w_func = c_alu_sub;
          3'b100, 3'b101: w_func = c_alu_slt;
          3'b110, 3'b111: w_func = c_alu_sltu;
          default:        w_illegal = 1'b1;
        endcase
      end
      default: w_illegal = 1'b1;
    endcase
    if (w_illegal) begin
      w_we        = 1'b0;
      w_is_load   = 1'b0;
      w_is_store  = 1'b0;
      w_is_branch = 1'b0;
      w_is_jump   = 1'b0;
    end
    if (w_rd == '0) w_we = 1'b0;
  end

  function automatic logic [XLEN-1:0] in_addr_head();
    return r_addr0;
  endfunction

  assign w_head_valid = (r_count != 2'd0);
  assign w_hazard     = haz_load && (haz_rd != '0) &&
                        ((w_use_rs1 && (haz_rd == w_rs1)) || (w_use_rs2 && (haz_rd == w_rs2)));
  assign w_issue      = !flush && w_head_valid && !w_hazard && (!r_out_valid || out_ready);
  assign w_push       = !flush && in_valid && r_in_ready;

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_issue)      w_count_next = r_count + 2'd1;
    else if (!w_push && w_issue) w_count_next = r_count - 2'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_inst0    <= '0;
      r_inst1    <= '0;
      r_addr0    <= '0;
      r_addr1    <= '0;
      r_count    <= 2'd0;
      r_in_ready <= 1'b1;
    end else if (flush) begin
      r_count    <= 2'd0;
      r_in_ready <= 1'b1;
    end else begin
      r_count    <= w_count_next;
      r_in_ready <= (w_count_next < 2'd2);
      // Entry 0 refills from entry 1 on pop, or from the input when it empties.
      if (w_issue) begin
        if (r_count == 2'd2) begin
          r_inst0 <= r_inst1;
          r_addr0 <= r_addr1;
          if (w_push) begin
            r_inst1 <= in_inst;
            r_addr1 <= in_addr;
          end
        end else if (w_push) begin
          r_inst0 <= in_inst;
          r_addr0 <= in_addr;
        end
      end else if (w_push) begin
        if (r_count == 2'd0) begin
          r_inst0 <= in_inst;
          r_addr0 <= in_addr;
        end else begin
          r_inst1 <= in_inst;
          r_addr1 <= in_addr;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid   <= 1'b0;
      r_out_inst    <= '0;
      r_out_addr    <= '0;
      r_out_we      <= 1'b0;
      r_out_rd      <= '0;
      r_out_op1     <= '0;
      r_out_op2     <= '0;
      r_out_func    <= '0;
      r_out_imm     <= '0;
      r_out_sdata   <= '0;
      r_out_load    <= 1'b0;
      r_out_store   <= 1'b0;
      r_out_branch  <= 1'b0;
      r_out_jump    <= 1'b0;
      r_out_illegal <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_issue) begin
      r_out_valid   <= 1'b1;
      r_out_inst    <= r_inst0;
      r_out_addr    <= r_addr0;
      r_out_we      <= w_we;
      r_out_rd      <= w_rd;
      r_out_op1     <= w_op1;
      r_out_op2     <= w_op2;
      r_out_func    <= w_func;
      r_out_imm     <= w_imm;
      r_out_sdata   <= reg2_rdata;
      r_out_load    <= w_is_load;
      r_out_store   <= w_is_store;
      r_out_branch  <= w_is_branch;
      r_out_jump    <= w_is_jump;
      r_out_illegal <= w_illegal;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready       = r_in_ready;
  assign out_valid      = r_out_valid;
  assign out_inst       = r_out_inst;
  assign out_addr       = r_out_addr;
  assign out_we         = r_out_we;
  assign out_rd         = r_out_rd;
  assign out_opnum1     = r_out_op1;
  assign out_opnum2     = r_out_op2;
  assign out_alu_func   = r_out_func;
  assign out_imm        = r_out_imm;
  assign out_store_data = r_out_sdata;
  assign out_is_load    = r_out_load;
  assign out_is_store   = r_out_store;
  assign out_is_branch  = r_out_branch;
  assign out_is_jump    = r_out_jump;
  assign out_illegal    = r_out_illegal;

endmodule

`default_nettype wire

// File: tb/tb_core_id_pipe.sv
// ============================================================================
// Module   : tb_core_id_pipe
// Purpose  : Directed self-checking bench for core_id_pipe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_core_id_pipe;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_addr;
  logic [4:0]  reg1_raddr, reg2_raddr;
  logic [31:0] reg1_rdata, reg2_rdata;
  logic        haz_load;
  logic [4:0]  haz_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst, out_addr;
  logic        out_we;
  logic [4:0]  out_rd;
  logic [31:0] out_opnum1, out_opnum2;
  logic [3:0]  out_alu_func;
  logic [31:0] out_imm, out_store_data;
  logic        out_is_load, out_is_store, out_is_branch, out_is_jump, out_illegal;

  int total = 0;
  int bad   = 0;

  // Register file model: x1=5, x2=7, everything else 0.
  assign reg1_rdata = (reg1_raddr == 5'd1) ? 32'd5 : (reg1_raddr == 5'd2) ? 32'd7 : 32'd0;
  assign reg2_rdata = (reg2_raddr == 5'd1) ? 32'd5 : (reg2_raddr == 5'd2) ? 32'd7 : 32'd0;

  core_id_pipe #(.XLEN(32), .RA_W(5), .ALU_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_addr(in_addr),
    .reg1_raddr(reg1_raddr), .reg2_raddr(reg2_raddr),
    .reg1_rdata(reg1_rdata), .reg2_rdata(reg2_rdata),
    .haz_load(haz_load), .haz_rd(haz_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr), .out_we(out_we), .out_rd(out_rd),
    .out_opnum1(out_opnum1), .out_opnum2(out_opnum2), .out_alu_func(out_alu_func),
    .out_imm(out_imm), .out_store_data(out_store_data),
    .out_is_load(out_is_load), .out_is_store(out_is_store), .out_is_branch(out_is_branch),
    .out_is_jump(out_is_jump), .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction and return just after the edge that accepts it.
  task automatic push(input logic [31:0] i, input logic [31:0] a);
    int k;
    k = 0;
    in_valid = 1'b1;
    in_inst  = i;
    in_addr  = a;
    while (!in_ready && k < 20) begin
      step();
      k++;
    end
    total++;
    if (!in_ready) begin
      bad++;
      $display("FAIL push_timeout in_ready=%0b required=1", in_ready);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
    total++;
    if ({out_inst, out_opnum1, out_opnum2, out_imm} !== 128'd0) begin
      bad++; $display("FAIL reset_out_zero got=%h want=0", {out_inst, out_opnum1, out_opnum2, out_imm});
    end
    total++;
    if ({out_we, out_alu_func, out_is_load, out_is_store, out_is_branch, out_is_jump, out_illegal} !== 10'd0) begin
      bad++; $display("FAIL reset_flags got=%h want=0",
                      {out_we, out_alu_func, out_is_load, out_is_store, out_is_branch, out_is_jump, out_illegal});
    end
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    push(32'h002081B3, 32'h0000_0040);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL add_latency out_valid=%0b want=0", out_valid); end
    step();
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%0b want=1", out_valid); end
    total++;
    if ({out_alu_func, out_opnum1, out_opnum2, out_rd, out_we} !== {4'd0, 32'd5, 32'd7, 5'd3, 1'b1}) begin
      bad++; $display("FAIL add_fields func=%0d op1=%0d op2=%0d rd=%0d we=%0b want 0/5/7/3/1",
                      out_alu_func, out_opnum1, out_opnum2, out_rd, out_we);
    end
    total++;
    if (out_addr !== 32'h40) begin bad++; $display("FAIL add_addr got=%h want=00000040", out_addr); end
    step();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL add_bubble got=%0b want=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    push(32'h00100293, 32'h100);
    push(32'h00200293, 32'h104);
    push(32'h00300293, 32'h108);
    for (int c = 0; c < 3; c++) begin
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_in_ready_full c=%0d got=%0b want=0", c, in_ready); end
      total++;
      if (out_valid !== 1'b1 || out_inst !== 32'h00100293 || out_opnum2 !== 32'd1) begin
        bad++; $display("FAIL b2b_hold c=%0d valid=%0b inst=%h op2=%0d want 1/00100293/1",
                        c, out_valid, out_inst, out_opnum2);
      end
      if (c < 2) step();
    end
    out_ready = 1'b1;
    step();
    total++;
    if (out_valid !== 1'b1 || out_inst !== 32'h00200293 || out_opnum2 !== 32'd2 || out_addr !== 32'h104) begin
      bad++; $display("FAIL b2b_second valid=%0b inst=%h op2=%0d addr=%h", out_valid, out_inst, out_opnum2, out_addr);
    end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready_reopen got=%0b want=1", in_ready); end
    step();
    total++;
    if (out_valid !== 1'b1 || out_inst !== 32'h00300293 || out_opnum2 !== 32'd3 || out_addr !== 32'h108) begin
      bad++; $display("FAIL b2b_third valid=%0b inst=%h op2=%0d addr=%h", out_valid, out_inst, out_opnum2, out_addr);
    end
    step();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%0b want=0", out_valid); end
  endtask

  task automatic test_hazard();
    out_ready = 1'b1;
    haz_load  = 1'b1;
    haz_rd    = 5'd1;
    push(32'h0020A423, 32'h200);
    for (int c = 0; c < 3; c++) begin
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL haz_rs1_stall c=%0d got=%0b want=0", c, out_valid); end
      step();
    end
    haz_rd = 5'd2;
    step();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL haz_rs2_stall got=%0b want=0", out_valid); end
    haz_load = 1'b0;
    step();
    total++;
    if (out_valid !== 1'b1 || out_is_store !== 1'b1) begin
      bad++; $display("FAIL haz_release valid=%0b is_store=%0b want 1/1", out_valid, out_is_store);
    end
    total++;
    if ({out_opnum1, out_opnum2, out_store_data, out_we} !== {32'd5, 32'd8, 32'd7, 1'b0}) begin
      bad++; $display("FAIL haz_store_fields op1=%0d op2=%0d sdata=%0d we=%0b want 5/8/7/0",
                      out_opnum1, out_opnum2, out_store_data, out_we);
    end
    haz_load = 1'b1;
    haz_rd   = 5'd3;
    push(32'h123451B7, 32'h204);
    step();
    total++;
    if (out_valid !== 1'b1 || out_opnum2 !== 32'h12345000) begin
      bad++; $display("FAIL haz_lui_no_stall valid=%0b op2=%h want 1/12345000", out_valid, out_opnum2);
    end
    haz_load = 1'b0;
    haz_rd   = 5'd0;
    step();
  endtask

  task automatic test_branch();
    out_ready = 1'b1;
    push(32'hFE000EE3, 32'h300);
    step();
    total++;
    if (out_imm !== 32'hFFFFFFFC) begin bad++; $display("FAIL beq_imm got=%h want=fffffffc", out_imm); end
    total++;
    if ({out_valid, out_is_branch, out_alu_func, out_we} !== {1'b1, 1'b1, 4'd1, 1'b0}) begin
      bad++; $display("FAIL beq_flags valid=%0b br=%0b func=%0d we=%0b want 1/1/1/0",
                      out_valid, out_is_branch, out_alu_func, out_we);
    end
    step();
  endtask

  logic [31:0] vi  [10];
  logic [31:0] va  [10];
  logic [31:0] vo1 [10];
  logic [31:0] vo2 [10];
  logic [3:0]  vf  [10];
  logic [31:0] vim [10];
  logic        vwe [10];
  logic [4:0]  vfl [10];

  task automatic test_decode();
    // flags: {load, store, branch, jump, illegal}
    vi  = '{32'h40208233, 32'h4020D333, 32'h4030D393, 32'h123451B7, 32'h00001197,
            32'h008000EF, 32'h00C080E7, 32'h0040A183, 32'h0020E063, 32'h00208033};
    va  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h100, 32'h200, 32'h300, 32'h0, 32'h0, 32'h0};
    vo1 = '{32'd5, 32'd5, 32'd5, 32'd0, 32'h100, 32'h200, 32'h300, 32'd5, 32'd5, 32'd5};
    vo2 = '{32'd7, 32'd7, 32'd3, 32'h12345000, 32'h1000, 32'd4, 32'd4, 32'd4, 32'd7, 32'd7};
    vf  = '{4'd1, 4'd7, 4'd7, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd9, 4'd0};
    vim = '{32'd0, 32'd0, 32'h403, 32'h12345000, 32'h1000, 32'd8, 32'd12, 32'd4, 32'd0, 32'd0};
    vwe = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vfl = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000,
            5'b00010, 5'b00010, 5'b10000, 5'b00100, 5'b00000};
    out_ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      push(vi[n], va[n]);
      step();
      total++;
      if (out_valid !== 1'b1 || out_inst !== vi[n]) begin
        bad++; $display("FAIL dec%0d_valid valid=%0b inst=%h want 1/%h", n, out_valid, out_inst, vi[n]);
      end
      total++;
      if (out_opnum1 !== vo1[n] || out_opnum2 !== vo2[n]) begin
        bad++; $display("FAIL dec%0d_ops op1=%h op2=%h want %h/%h", n, out_opnum1, out_opnum2, vo1[n], vo2[n]);
      end
      total++;
      if (out_alu_func !== vf[n] || out_imm !== vim[n]) begin
        bad++; $display("FAIL dec%0d_func_imm func=%0d imm=%h want %0d/%h", n, out_alu_func, out_imm, vf[n], vim[n]);
      end
      total++;
      if (out_we !== vwe[n] ||
          {out_is_load, out_is_store, out_is_branch, out_is_jump, out_illegal} !== vfl[n]) begin
        bad++; $display("FAIL dec%0d_we_flags we=%0b flags=%b want %0b/%b", n, out_we,
                        {out_is_load, out_is_store, out_is_branch, out_is_jump, out_illegal}, vwe[n], vfl[n]);
      end
    end
    push(32'h0000007F, 32'h400);
    step();
    total++;
    if ({out_valid, out_we, out_is_load, out_is_store, out_is_branch, out_is_jump, out_illegal} !== 7'b1000001) begin
      bad++; $display("FAIL illegal_opcode got=%b want=1000001",
                      {out_valid, out_we, out_is_load, out_is_store, out_is_branch, out_is_jump, out_illegal});
    end
    push(32'h022081B3, 32'h404);
    step();
    total++;
    if ({out_valid, out_we, out_illegal} !== 3'b101) begin
      bad++; $display("FAIL illegal_funct7 got=%b want=101", {out_valid, out_we, out_illegal});
    end
    step();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    push(32'h00100293, 32'h500);
    push(32'h00200293, 32'h504);
    push(32'h00300293, 32'h508);
    in_valid = 1'b1;
    in_inst  = 32'h00900293;
    in_addr  = 32'h50C;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL flush_clear valid=%0b in_ready=%0b want 0/1", out_valid, in_ready);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      total++;
      if (out_valid !== 1'b0) begin
        bad++; $display("FAIL flush_stale c=%0d valid=%0b inst=%h want valid 0", c, out_valid, out_inst);
      end
    end
    push(32'h00400293, 32'h510);
    step();
    total++;
    if (out_valid !== 1'b1 || out_opnum2 !== 32'd4 || out_addr !== 32'h510) begin
      bad++; $display("FAIL flush_resume valid=%0b op2=%0d addr=%h want 1/4/00000510", out_valid, out_opnum2, out_addr);
    end
    step();
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    push(32'h00100293, 32'h600);
    push(32'h00200293, 32'h604);
    push(32'h00300293, 32'h608);
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL midreset_immediate valid=%0b in_ready=%0b want 0/1", out_valid, in_ready);
    end
    step();
    rst       = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      total++;
      if (out_valid !== 1'b0) begin
        bad++; $display("FAIL midreset_stale c=%0d valid=%0b inst=%h want valid 0", c, out_valid, out_inst);
      end
    end
  endtask

  initial begin
    rst       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_inst   = '0;
    in_addr   = '0;
    haz_load  = 1'b0;
    haz_rd    = '0;
    out_ready = 1'b0;
    step();
    step();
    test_reset();
    rst = 1'b1;
    step();
    test_add();
    test_back_to_back();
    test_hazard();
    test_branch();
    test_decode();
    test_flush();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
